load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
// - MEM-stage sequencer between the EX/MEM pipeline register and data_mem.
// - Accepts one load/store request at a time and validates funct3 and alignment.
// - Inserts WAIT_CYCLES wait states, then drives data_mem enables for exactly one cycle.
// - Returns a one-cycle response (load data or store completion, or error) toward WB; stalls upstream via req_ready.
// PARAMETERS
// - WIDTH        32  data/address width
// - WAIT_CYCLES  0   wait states before the access cycle (0..15)
// PORTS
// - clk          in   1      single clock, rising edge
// - rst          in   1      asynchronous, active-low reset
// - req_valid    in   1      request present from EX/MEM
// - req_ready    out  1      high only in IDLE; handshake = req_valid & req_ready
// - req_we       in   1      1 = store, 0 = load
// - req_funct3   in   3      RV32I load/store funct3
// - req_addr     in   WIDTH  byte address
// - req_wdata    in   WIDTH  store data, unshifted (data_mem packs bytes)
// - req_rd       in   5      load destination register, echoed on rsp_rd
// - flush        in   1      pipeline flush; cancels a request not yet in ACCESS
// - mem_addr     out  WIDTH  to data_mem addr
// - mem_data_in  out  WIDTH  to data_mem data_in
// - mem_wr_en    out  1      to data_mem wr_en
// - mem_rd_en    out  1      to data_mem rd_en
// - mem_funct3   out  3      to data_mem funct3
// - mem_data_out in   WIDTH  from data_mem (combinational read)
// - rsp_valid    out  1      one-cycle response pulse
// - rsp_err      out  1      with rsp_valid: misaligned or illegal funct3
// - rsp_rdata    out  WIDTH  load result; 0 for stores and errors
// - rsp_rd       out  5      latched req_rd
// BEHAVIOUR
// Reset (rst=0, async):
// - state=IDLE; mem_wr_en=0, mem_rd_en=0, rsp_valid=0, rsp_err=0.
// - rsp_rdata=0, rsp_rd=0, mem_addr/mem_data_in/mem_funct3=0, wait counter=0.
// - req_ready=1 after release.
// - Reset during ACCESS drops mem_wr_en immediately; a store in progress does not commit.
// States: IDLE, WAIT, ACCESS, RESP.
// - IDLE: on handshake, latch we/funct3/addr/wdata/rd.
//   - Error if load funct3 is in {011,110,111}, or store funct3 > 010 -> RESP, rsp_err=1.
//   - Error if half access has addr[0]=1, or word access has addr[1:0]!=0 -> RESP, rsp_err=1.
//   - Else go to WAIT (counter=WAIT_CYCLES-1) if WAIT_CYCLES>0, otherwise ACCESS.
// - WAIT: decrement counter; go to ACCESS when counter==0.
// - ACCESS: mem_* = latched values; exactly one of mem_wr_en/mem_rd_en=1 for exactly this cycle.
//   - Load: rsp_rdata <= mem_data_out at the closing edge. Next state RESP.
// - RESP: rsp_valid=1 for one cycle (loads, stores, errors); next state IDLE.
//   - WB always accepts; there is no response backpressure.
// Latency:
// - Handshake at edge N: ACCESS occupies cycle N+1+WAIT_CYCLES; rsp_valid in cycle N+2+WAIT_CYCLES.
// - Error response: rsp_valid in cycle N+1, no memory access.
// Flush:
// - In IDLE: the handshake is suppressed (no accept).
// - In WAIT: go to IDLE, no access, no response.
// - In ACCESS or RESP: ignored; the store commits and the response is still issued.
// Outside ACCESS:
// - mem_wr_en=mem_rd_en=0; mem_addr/mem_data_in/mem_funct3 hold their last latched value.
// - rsp_rdata, rsp_err and rsp_rd are held outside RESP; they are qualified by rsp_valid only.
// - Store response: rsp_rdata=0.
// STRUCTURE
// - lsu_pkg:
//   - lsu_state_t enum {IDLE, WAIT, ACCESS, RESP}.
//   - funct3 localparams F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
//   - MAX_WAIT=15.
// - Sub-module lsu_align_check (combinational): inputs we, funct3, addr[1:0]; output err.
// - Top: FSM, wait counter, request/response registers.
// TESTING
// - SW addr=0x100 wdata=0xDEADBEEF, WAIT_CYCLES=0 -> mem_wr_en=1 in exactly one cycle; rsp_valid 2 cycles after the accept edge, rsp_err=0.
// - LW 0x100 after that store -> rsp_rdata=0xDEADBEEF, rsp_rd=req_rd.
//   - LB 0x103 -> 0xFFFFFFDE; LBU 0x103 -> 0x000000DE.
// - LW 0x102, LH 0x101, and a store with funct3=011 -> each gives rsp_err=1 one cycle after accept.
//   - mem_wr_en and mem_rd_en never assert; memory content is unchanged.
// - WAIT_CYCLES=3, LH 0x100 -> req_ready low 5 cycles; ACCESS in cycle N+4; rsp_valid in cycle N+5.
//   - rsp_rdata=0xFFFFBEEF.
// - WAIT_CYCLES=3, SB 0x100 wdata 0x55, flush in the first WAIT cycle -> no mem_wr_en, no rsp_valid.
//   - A following LW 0x100 returns 0xDEADBEEF.
// - SW asserted with rst low in its ACCESS cycle -> mem_wr_en falls asynchronously and no rsp_valid.
//   - State=IDLE; req_ready=1 after reset release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// load/store funct3 encodings and the wait-state limit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int MAX_WAIT   = 15;
    localparam int WAIT_CNT_W = $clog2(MAX_WAIT + 1);

    // Stores only come in signed-less byte/half/word flavours; loads add BU/HU.
    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        if (we) begin
            return funct3 inside {F3_B, F3_H, F3_W};
        end
        return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/lsu_align_check.sv
// Combinational request validator: flags illegal funct3 codes and
// misaligned half/word addresses.
module lsu_align_check
    import lsu_pkg::*;
(
    input  logic       we,
    input  logic [2:0] funct3,
    input  logic [1:0] addr,
    output logic       err
);

    logic misaligned;

    always_comb begin
        // NOTE: default first so every path assigns misaligned; a missing path would infer a latch.
        misaligned = 1'b0;
        case (funct3)
            F3_H, F3_HU: misaligned = addr[0];
            F3_W:        misaligned = (addr != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    end

    assign err = !funct3_legal(we, funct3) || misaligned;

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage sequencer: accepts one load/store, validates it, inserts wait
// states, pulses the data_mem enables for one cycle and returns a response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [4:0]       req_rd,
    input  logic             flush,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_data_in,
    output logic             mem_wr_en,
    output logic             mem_rd_en,
    output logic [2:0]       mem_funct3,
    input  logic [WIDTH-1:0] mem_data_out,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic [4:0]       rsp_rd
);

    // Counter preload; the WAIT state is never entered when WAIT_CYCLES is 0.
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
        WAIT_CNT_W'(((WAIT_CYCLES > 0) ? WAIT_CYCLES : 1) - 1);

    lsu_state_t            state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  we_q;
    logic [4:0]            rd_q;
    logic                  req_err;
    logic                  accept;

    lsu_align_check u_align_check (
        .we     (req_we),
        .funct3 (req_funct3),
        .addr   (req_addr[1:0]),
        .err    (req_err)
    );

    assign req_ready = (state == IDLE);
    // A flush in IDLE suppresses the handshake rather than cancelling later.
    assign accept    = req_valid && req_ready && !flush;

    // mem_addr/mem_data_in/mem_funct3 double as the latched request, so they
    // naturally hold their last value outside ACCESS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            we_q        <= 1'b0;
            rd_q        <= '0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            mem_funct3  <= '0;
            mem_wr_en   <= 1'b0;
            mem_rd_en   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            rsp_rd      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q        <= req_we;
                        rd_q        <= req_rd;
                        mem_addr    <= req_addr;
                        mem_data_in <= req_wdata;
                        mem_funct3  <= req_funct3;
                        if (req_err) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_rd    <= req_rd;
                        end else if (WAIT_CYCLES > 0) begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_INIT;
                        end else begin
                            state     <= ACCESS;
                            mem_wr_en <= req_we;
                            mem_rd_en <= ~req_we;
                        end
                    end
                end

                WAIT: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (wait_cnt == '0) begin
                        state     <= ACCESS;
                        mem_wr_en <= we_q;
                        mem_rd_en <= ~we_q;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                ACCESS: begin
                    // Flush is ignored from here on: the access is committed.
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= we_q ? '0 : mem_data_out;
                    rsp_rd    <= rd_q;
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
